fetch_pc_unit: RTL

- Program-counter and instruction-fetch stage of the RISC-V core; sits directly upstream of decode and the branch comparator, and consumes that comparator's taken result.
- Holds the PC and fetches one instruction per handshake from instruction memory.
- Presents the instruction until the core retires it, then selects the next PC: sequential, branch, JAL or JALR.
- Keeps a retired-instruction counter.

---
 rtl/core_pkg.sv | 29 ++
 rtl/next_pc_sel.sv | 46 ++++
 rtl/fetch_pc_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared fetch-stage types: FSM states, next-PC select codes and control payload.
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC
  } fetch_state_t;

  typedef enum logic [2:0] {
    PC_SEQ,
    PC_BR,
    PC_JAL,
    PC_JALR,
    PC_TRAP
  } pc_sel_t;

  // Control-flow bits from decode and the branch comparator for the current instruction.
  typedef struct packed {
    logic branch;
    logic branch_taken;
    logic jal;
    logic jalr;
  } npc_ctrl_t;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: picks sequential/branch/JAL/JALR target, redirects misaligned
// control-transfer targets to the trap vector.
// Ports: pc, imm, rs1, ctrl in; next_pc_c (selected PC), sel_c (which source won) out.
module next_pc_sel
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  npc_ctrl_t       ctrl,
  output logic [XLEN-1:0] next_pc_c,
  output pc_sel_t         sel_c
);

  logic [XLEN-1:0] tgt;
  pc_sel_t         sel;

  // Priority: jalr > jal > taken branch > sequential.
  always_comb begin
    tgt = pc + XLEN'(4);
    sel = PC_SEQ;
    if (ctrl.jalr) begin
      tgt = (rs1 + imm) & ~XLEN'(1);
      sel = PC_JALR;
    end else if (ctrl.jal) begin
      tgt = pc + imm;
      sel = PC_JAL;
    end else if (ctrl.branch && ctrl.branch_taken) begin
      tgt = pc + imm;
      sel = PC_BR;
    end
  end

  // Only redirects can be misaligned; pc+4 from an aligned pc never is.
  always_comb begin
    next_pc_c = tgt;
    sel_c     = sel;
    if (sel != PC_SEQ && tgt[1]) begin
      next_pc_c = TRAP_VECTOR;
      sel_c     = PC_TRAP;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC and instruction-fetch stage: fetches one instruction per handshake, holds it
// until retired, then advances the PC and counts retired instructions.
// Ports: clk, rst_n; imem_req/imem_addr/imem_rdata/imem_ready memory handshake;
// instr/instr_valid/pc/pc_plus4 to decode; retire/stall/branch/branch_taken/jal/jalr/
// imm/rs1 next-PC inputs; misalign_err pulse; instret retired count.
module fetch_pc_unit
  import core_pkg::*;
#(
  parameter int unsigned     XLEN_P       = XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [XLEN_P-1:0] imem_addr,
  input  logic [XLEN_P-1:0] imem_rdata,
  input  logic              imem_ready,
  output logic [XLEN_P-1:0] instr,
  output logic              instr_valid,
  output logic [XLEN_P-1:0] pc,
  output logic [XLEN_P-1:0] pc_plus4,
  input  logic              retire,
  input  logic              stall,
  input  logic              branch,
  input  logic              branch_taken,
  input  logic              jal,
  input  logic              jalr,
  input  logic [XLEN_P-1:0] imm,
  input  logic [XLEN_P-1:0] rs1,
  output logic              misalign_err,
  output logic [XLEN_P-1:0] instret
);

  fetch_state_t    state;
  npc_ctrl_t       ctrl;
  logic [XLEN-1:0] next_pc;
  pc_sel_t         sel;

  assign ctrl      = '{branch: branch, branch_taken: branch_taken, jal: jal, jalr: jalr};
  assign imem_addr = pc;
  assign pc_plus4  = pc + XLEN_P'(4);

  next_pc_sel #(
    .TRAP_VECTOR(TRAP_VECTOR)
  ) u_next_pc_sel (
    .pc       (pc),
    .imm      (imm),
    .rs1      (rs1),
    .ctrl     (ctrl),
    .next_pc_c(next_pc),
    .sel_c    (sel)
  );

  // Fetch FSM with registered handshake/status outputs; imem_req is raised on
  // entry to FETCH so it is valid for the whole FETCH state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_VECTOR;
      imem_req     <= 1'b0;
      instr        <= NOP_INSTR;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
      instret      <= '0;
    end else begin
      misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          imem_req <= 1'b1;
          state    <= FETCH;
        end
        FETCH: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (retire && !stall) begin
            pc           <= next_pc;
            instret      <= instret + XLEN_P'(1);
            instr_valid  <= 1'b0;
            imem_req     <= 1'b1;
            misalign_err <= (sel == PC_TRAP);
            state        <= FETCH;
          end
        end
        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
